p66btxsched: RTL and testbench

Transmit block scheduler for the 10GBASE-R PCS transmit path. It sits between the 64b/66b encoder's packet stream and the 66b-to-32b TX gearbox, and always presents a valid 66-bit block whenever the gearbox asks for one. Blocks come from one of three sources: packet blocks from the encoder, idle fill, or fault ordered sets. The block enforces frame integrity: encoder underflow and link loss mid-frame are turned into error blocks.

---
 rtl/p66b_pkg.sv | 33 +++
 rtl/p66btxsched.sv | 135 +++++++++++++
 tb/tb_p66btxsched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/p66b_pkg.sv
// Shared constants and types for the 10GBASE-R transmit block scheduler:
// sync headers, block types, fixed 66-bit blocks and the scheduler state enum.
package p66b_pkg;

    localparam logic [1:0] SyncData = 2'b01;
    localparam logic [1:0] SyncCtrl = 2'b10;

    localparam logic [7:0] BtIdle  = 8'h1E;
    localparam logic [7:0] BtOrdSet = 8'h4B;
    localparam logic [7:0] BtStart = 8'h78;

    localparam logic [6:0] CcError = 7'h1E;

    // Payload occupies [65:10]; first payload byte sits at [17:10].
    localparam logic [65:0] BlkIdle = {56'h0, BtIdle, SyncCtrl};
    localparam logic [65:0] BlkErr  = {{8{CcError}}, BtIdle, SyncCtrl};
    localparam logic [65:0] BlkLf   = {32'h0, 8'h01, 8'h00, 8'h00, BtOrdSet, SyncCtrl};
    localparam logic [65:0] BlkRf   = {32'h0, 8'h02, 8'h00, 8'h00, BtOrdSet, SyncCtrl};

    localparam logic [2:0] GuardInit = 3'd4;

    typedef enum logic [1:0] {
        StFault,
        StIdle,
        StPkt,
        StDrain
    } state_e;

    function automatic logic is_start(input logic [65:0] blk);
        return (blk[1:0] == SyncCtrl) && (blk[9:2] == BtStart);
    endfunction

endpackage

// File: rtl/p66btxsched.sv
// Transmit block scheduler: always presents a valid 66b block to the gearbox,
// choosing between encoder packet blocks, idle fill and fault ordered sets.
module p66btxsched
    import p66b_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_link_up,
    input  logic        i_remote_fault,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [65:0] S_DATA,
    input  logic        S_LAST,
    input  logic        M_READY,
    output logic [65:0] M_DATA,
    output logic        o_underflow,
    output logic        o_abort
);

    state_e      state_q, state_d;
    logic [65:0] data_q, data_d;
    logic [2:0]  guard_q, guard_d;
    logic        underflow_q, underflow_d;
    logic        abort_q, abort_d;
    logic        s_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        guard_d     = guard_q;
        underflow_d = 1'b0;
        abort_d     = 1'b0;
        s_ready     = 1'b0;

        unique case (state_q)
            StFault: begin
                if (M_READY) begin
                    if (!i_link_up) begin
                        data_d  = BlkLf;
                        guard_d = GuardInit;
                    end else begin
                        data_d  = BlkIdle;
                        guard_d = guard_q - 3'd1;
                        if (guard_q <= 3'd1) state_d = StIdle;
                    end
                end
            end

            StIdle: begin
                if (M_READY) begin
                    if (!i_link_up) begin
                        data_d  = BlkLf;
                        guard_d = GuardInit;
                        state_d = StFault;
                    end else if (i_remote_fault) begin
                        data_d = BlkRf;
                    end else if (S_VALID && is_start(S_DATA)) begin
                        s_ready = 1'b1;
                        data_d  = S_DATA;
                        if (!S_LAST) state_d = StPkt;
                    end else if (S_VALID) begin
                        // Stray mid-frame beat: swallow it and resync on its S_LAST.
                        s_ready = 1'b1;
                        data_d  = BlkIdle;
                        if (!S_LAST) state_d = StDrain;
                    end else begin
                        data_d = BlkIdle;
                    end
                end
            end

            StPkt: begin
                if (M_READY) begin
                    if (!i_link_up) begin
                        data_d  = BlkErr;
                        abort_d = 1'b1;
                        guard_d = GuardInit;
                        state_d = StFault;
                    end else if (S_VALID) begin
                        s_ready = 1'b1;
                        data_d  = S_DATA;
                        if (S_LAST) state_d = StIdle;
                    end else begin
                        data_d      = BlkErr;
                        underflow_d = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end

            StDrain: begin
                // Discard continues even while the gearbox is stalled.
                s_ready = 1'b1;
                if (S_VALID && S_LAST) state_d = StIdle;
                if (M_READY) begin
                    if (!i_link_up) begin
                        data_d  = BlkLf;
                        guard_d = GuardInit;
                        state_d = StFault;
                    end else begin
                        data_d = BlkIdle;
                    end
                end
            end

            default: begin
                state_d = StFault;
                data_d  = BlkLf;
                guard_d = GuardInit;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StFault;
            data_q      <= BlkLf;
            guard_q     <= GuardInit;
            underflow_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            guard_q     <= guard_d;
            underflow_q <= underflow_d;
            abort_q     <= abort_d;
        end
    end

    assign S_READY     = s_ready && !i_reset;
    assign M_DATA      = data_q;
    assign o_underflow = underflow_q;
    assign o_abort     = abort_q;

endmodule

// File: tb/tb_p66btxsched.sv
// Directed bench for p66btxsched: one table-driven run through link bring-up
// and a framed packet, then hand-written underflow/abort/remote-fault/reset cases.
module tb_p66btxsched;

    logic        clk;
    logic        rst;
    logic        link_up;
    logic        remote_fault;
    logic        s_valid;
    logic        s_ready;
    logic [65:0] s_data;
    logic        s_last;
    logic        m_ready;
    logic [65:0] m_data;
    logic        underflow;
    logic        abort;

    int n_pass;
    int n_total;

    localparam logic [65:0] LF   = 66'h400012E;
    localparam logic [65:0] RF   = 66'h800012E;
    localparam logic [65:0] IDL  = 66'h7A;
    localparam logic [65:0] ERR  = {{8{7'h1E}}, 8'h1E, 2'b10};
    localparam logic [65:0] STRT = {56'h55_5555_5555_5555, 8'h78, 2'b10};
    localparam logic [65:0] TERM = {56'h0, 8'hFF, 2'b10};
    localparam logic [65:0] D1   = {64'h1111_0000_AAAA_0001, 2'b01};
    localparam logic [65:0] D2   = {64'h2222_0000_BBBB_0002, 2'b01};
    localparam logic [65:0] D3   = {64'h3333_0000_CCCC_0003, 2'b01};
    localparam logic [65:0] D4   = {64'h4444_0000_DDDD_0004, 2'b01};
    localparam logic [65:0] D5   = {64'h5555_0000_EEEE_0005, 2'b01};
    localparam logic [65:0] D6   = {64'h6666_0000_FFFF_0006, 2'b01};

    typedef struct {
        logic        link;
        logic        rf;
        logic        sv;
        logic [65:0] sd;
        logic        sl;
        logic        mr;
        logic        exp_sr;
        logic [65:0] exp_md;
        logic        exp_uf;
        logic        exp_ab;
    } vec_t;

    vec_t vecs[$];

    p66btxsched dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_link_up      (link_up),
        .i_remote_fault (remote_fault),
        .S_VALID        (s_valid),
        .S_READY        (s_ready),
        .S_DATA         (s_data),
        .S_LAST         (s_last),
        .M_READY        (m_ready),
        .M_DATA         (m_data),
        .o_underflow    (underflow),
        .o_abort        (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic link, input logic rf, input logic sv,
                                input logic [65:0] sd, input logic sl, input logic mr,
                                input logic exp_sr, input logic [65:0] exp_md,
                                input logic exp_uf, input logic exp_ab);
        vec_t v;
        v.link = link; v.rf = rf; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.exp_sr = exp_sr; v.exp_md = exp_md; v.exp_uf = exp_uf; v.exp_ab = exp_ab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock: drive at negedge, check S_READY before the edge, outputs after it.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        link_up = v.link; remote_fault = v.rf; s_valid = v.sv;
        s_data = v.sd; s_last = v.sl; m_ready = v.mr;
        #1;
        chk({tag, " S_READY"}, {65'b0, s_ready}, {65'b0, v.exp_sr});
        @(posedge clk);
        #1;
        chk({tag, " M_DATA"}, m_data, v.exp_md);
        chk({tag, " underflow"}, {65'b0, underflow}, {65'b0, v.exp_uf});
        chk({tag, " abort"}, {65'b0, abort}, {65'b0, v.exp_ab});
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; link_up = 1'b0; remote_fault = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset M_DATA", m_data, LF);
        chk("reset S_READY", {65'b0, s_ready}, 66'b0);
        chk("reset underflow", {65'b0, underflow}, 66'b0);
        chk("reset abort", {65'b0, abort}, 66'b0);
        @(negedge clk);
        rst = 1'b0;

        //                link rf sv sd    sl mr  sr md    uf ab
        vecs.push_back(mk(0, 0, 1, STRT, 0, 1, 0, LF,   0, 0));
        vecs.push_back(mk(0, 0, 0, '0,   0, 0, 0, LF,   0, 0));
        vecs.push_back(mk(0, 0, 0, '0,   0, 1, 0, LF,   0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 1, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 0, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 1, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 1, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 1, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, STRT, 0, 1, 1, STRT, 0, 0));
        vecs.push_back(mk(1, 0, 1, D1,   0, 1, 1, D1,   0, 0));
        vecs.push_back(mk(1, 0, 1, D2,   0, 0, 0, D1,   0, 0));
        vecs.push_back(mk(1, 0, 1, D2,   0, 1, 1, D2,   0, 0));
        vecs.push_back(mk(1, 0, 1, D3,   0, 1, 1, D3,   0, 0));
        vecs.push_back(mk(1, 0, 1, D4,   0, 0, 0, D3,   0, 0));
        vecs.push_back(mk(1, 0, 1, D4,   0, 1, 1, D4,   0, 0));
        vecs.push_back(mk(1, 0, 1, D5,   0, 1, 1, D5,   0, 0));
        vecs.push_back(mk(1, 0, 1, D6,   0, 0, 0, D5,   0, 0));
        vecs.push_back(mk(1, 0, 1, D6,   0, 1, 1, D6,   0, 0));
        vecs.push_back(mk(1, 0, 1, TERM, 1, 1, 1, TERM, 0, 0));
        vecs.push_back(mk(1, 0, 0, '0,   0, 0, 0, TERM, 0, 0));
        vecs.push_back(mk(1, 0, 0, '0,   0, 1, 0, IDL,  0, 0));
        // Stray non-START beats in IDLE are dropped; DRAIN exits without M_READY.
        vecs.push_back(mk(1, 0, 1, D1,   1, 1, 1, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, D2,   0, 1, 1, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, D3,   0, 0, 1, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, TERM, 1, 0, 1, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 1, D1,   0, 0, 0, IDL,  0, 0));
        vecs.push_back(mk(1, 0, 0, '0,   0, 1, 0, IDL,  0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Underflow after three data beats, then drain through S_LAST.
        step("uf start", mk(1, 0, 1, STRT, 0, 1, 1, STRT, 0, 0));
        step("uf d1",    mk(1, 0, 1, D1,   0, 1, 1, D1,   0, 0));
        step("uf d2",    mk(1, 0, 1, D2,   0, 1, 1, D2,   0, 0));
        step("uf d3",    mk(1, 0, 1, D3,   0, 1, 1, D3,   0, 0));
        step("uf gap",   mk(1, 0, 0, '0,   0, 1, 0, ERR,  1, 0));
        step("uf d4",    mk(1, 0, 1, D4,   0, 0, 1, ERR,  0, 0));
        step("uf d5",    mk(1, 0, 1, D5,   0, 1, 1, IDL,  0, 0));
        step("uf term",  mk(1, 0, 1, TERM, 1, 1, 1, IDL,  0, 0));
        step("uf after", mk(1, 0, 0, '0,   0, 1, 0, IDL,  0, 0));

        // Link loss mid-frame: one ERR with abort, then LF and guard recovery.
        step("ab start", mk(1, 0, 1, STRT, 0, 1, 1, STRT, 0, 0));
        step("ab d1",    mk(1, 0, 1, D1,   0, 1, 1, D1,   0, 0));
        step("ab drop",  mk(0, 0, 1, D2,   0, 1, 0, ERR,  0, 1));
        step("ab lf",    mk(0, 0, 1, D2,   0, 1, 0, LF,   0, 0));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("ab guard%0d", i), mk(1, 0, 0, '0, 0, 1, 0, IDL, 0, 0));
        end

        // Remote fault holds a pending START; clearing it lets the frame start.
        step("rf 0",     mk(1, 1, 1, STRT, 0, 1, 0, RF,   0, 0));
        step("rf 1",     mk(1, 1, 1, STRT, 0, 1, 0, RF,   0, 0));
        step("rf stall", mk(1, 1, 1, STRT, 0, 0, 0, RF,   0, 0));
        step("rf clear", mk(1, 0, 1, STRT, 0, 1, 1, STRT, 0, 0));
        step("rf term",  mk(1, 0, 1, TERM, 1, 1, 1, TERM, 0, 0));
        step("rf idle",  mk(1, 0, 0, '0,   0, 1, 0, IDL,  0, 0));

        // Reset mid-frame goes straight to LF without accepting the beat.
        step("rst start", mk(1, 0, 1, STRT, 0, 1, 1, STRT, 0, 0));
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1; s_data = D1; s_last = 1'b0; m_ready = 1'b1;
        #1;
        chk("rst S_READY", {65'b0, s_ready}, 66'b0);
        @(posedge clk);
        #1;
        chk("rst M_DATA", m_data, LF);
        @(negedge clk);
        rst = 1'b0;
        step("rst fault", mk(1, 0, 1, STRT, 0, 1, 0, IDL, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
